// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampled UART receiver (start + DATA_BITS + stop, LSB first) with level-valid/read handshake.
// Define UART_RX_PARITY_EN to add a parity bit (even; odd when UART_RX_PARITY_ODD is also defined).
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state, w_state_next;
    logic                   r_rx_meta, r_rx_s;
    logic [TW-1:0]          r_tick_cnt, w_tick_next;
    logic [BW-1:0]          r_bit_cnt, w_bit_next;
    logic [DATA_BITS-1:0]   r_shift, w_shift_next;
    logic                   r_armed, w_armed_next;
    logic                   w_stop_eval;
    logic                   w_par_bad;
    logic                   w_load;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid, r_frame_err, r_overrun;

`ifdef UART_RX_PARITY_EN
`ifdef UART_RX_PARITY_ODD
    localparam logic PAR_ODD = 1'b1;
`else
    localparam logic PAR_ODD = 1'b0;
`endif
    logic r_par_bit, w_par_bit_next, r_parity_err;

    assign w_par_bad    = ((^r_shift) ^ r_par_bit) != PAR_ODD;
    assign parity_error = r_parity_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bit    <= w_par_bit_next;
            r_parity_err <= w_stop_eval && w_par_bad;
        end
    end
`else
    assign w_par_bad    = 1'b0;
    assign parity_error = 1'b0;
`endif

    // After a framing error the line must be seen high before a new start bit is accepted.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_armed_next = r_armed | r_rx_s;
        w_stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_next = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_armed) begin
                    w_state_next = S_START;
                    w_tick_next  = '0;
                end
            end
            S_START: begin
                if (tick_16x) begin
                    if (r_tick_cnt == MID) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick_16x) begin
                    if (r_tick_cnt == LAST) begin
                        w_tick_next  = '0;
                        w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_next   = r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_16x) begin
                    if (r_tick_cnt == LAST) begin
                        w_tick_next    = '0;
                        w_par_bit_next = r_rx_s;
                        w_state_next   = S_STOP;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick_16x) begin
                    if (r_tick_cnt == LAST) begin
                        w_tick_next  = '0;
                        w_stop_eval  = 1'b1;
                        w_state_next = S_IDLE;
                        if (!r_rx_s) w_armed_next = 1'b0;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
            end
        endcase
    end

    assign w_load = w_stop_eval && r_rx_s && !w_par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_armed     <= w_armed_next;
            r_frame_err <= w_stop_eval && !r_rx_s;
            r_overrun   <= w_load && r_rx_valid && !rx_read;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (rx_read) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign frame_error   = r_frame_err;
    assign overrun_error = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames at 54 clk per tick; expected latency derived from the bench's own tick count.
module tb_uart_rx;

    localparam int TICK_DIV = 54;
    localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // start sampled on 8th tick, each following bit on its 16th tick
    localparam int DONE_TICKS = 8 + 16 * (NBITS - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_16x = 1'b0;
    logic       rx = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, overrun_error, parity_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cyc = 0;
    logic valid_d = 1'b0;
    int start_cyc, done_k;
    int fe0, ov0, pe0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .tick_16x(tick_16x), .rx(rx), .rx_read(rx_read),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .overrun_error(overrun_error), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
            tick_16x = (tcnt == 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        valid_d <= rx_valid;
        if (rx_valid && !valid_d) rise_cyc <= cyc;
        if (frame_error)   fe_cnt <= fe_cnt + 1;
        if (overrun_error) ov_cnt <= ov_cnt + 1;
        if (parity_error)  pe_cnt <= pe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; optionally pulses rx_read on the edge that completes the stop decision.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              input bit read_at_done);
        logic [10:0] bits;
        int ticks, idx;
        bits   = {1'b1, par_bit, d, 1'b0};
        ticks  = 0;
        done_k = 0;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int k = 0; k < NBITS * BIT_CLK; k++) begin
            idx = k / BIT_CLK;
            rx  = (idx == NBITS - 1) ? stop_bit : bits[idx];
            @(negedge clk);
            rx_read = 1'b0;
            if (k >= 3 && tick_16x && done_k == 0) begin
                ticks++;
                if (ticks == DONE_TICKS) begin
                    done_k = k + 1;
                    if (read_at_done) rx_read = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        rx_read = 1'b0;
        $display("frame %02h stop=%0b: rx_valid=%0b rx_data=%02h", d, stop_bit, rx_valid, rx_data);
    endtask

    task automatic read_pulse();
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_fe", 32'(frame_error), 32'd0);
        chk("rst_ov", 32'(overrun_error), 32'd0);
        chk("rst_pe", 32'(parity_error), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // good frame 0xA5
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_latency", 32'(rise_cyc), 32'(start_cyc + done_k));
        chk("a5_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("a5_ov", 32'(ov_cnt - ov0), 32'd0);
        chk("a5_pe", 32'(pe_cnt - pe0), 32'd0);
        read_pulse();
        chk("a5_read_clears", 32'(rx_valid), 32'd0);
        chk("a5_data_kept", 32'(rx_data), 32'hA5);
        read_pulse();
        chk("idle_read_ignored", 32'(rx_valid), 32'd0);

        // short start glitch
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5 * TICK_DIV) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        $display("glitch: rx_valid=%0b frame_errors=%0d", rx_valid, fe_cnt - fe0);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // bad stop bit, then line held low for three frame times
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("fe_one_cycle", 32'(fe_cnt - fe0), 32'd1);
        chk("fe_valid", 32'(rx_valid), 32'd0);
        chk("fe_data_kept", 32'(rx_data), 32'hA5);
        repeat (3 * 10 * BIT_CLK) @(negedge clk);
        chk("break_single_fe", 32'(fe_cnt - fe0), 32'd1);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        $display("break released: frame_errors=%0d rx_valid=%0b", fe_cnt - fe0, rx_valid);
        chk("break_release_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("break_valid", 32'(rx_valid), 32'd0);

        // overrun: two frames with no read, then one with read on the completing edge
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        chk("rearm_data", 32'(rx_data), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovr_data", 32'(rx_data), 32'h22);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("rd_coinc_ov", 32'(ov_cnt - ov0), 32'd1);
        chk("rd_coinc_data", 32'(rx_data), 32'h44);
        chk("rd_coinc_valid", 32'(rx_valid), 32'd1);

        // reset in the middle of the data bits of 0xFF
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'd0);
        chk("midrst_fe", 32'(frame_error), 32'd0);
        chk("midrst_ov", 32'(overrun_error), 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("postrst_valid", 32'(rx_valid), 32'd0);
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("5a_data", 32'(rx_data), 32'h5A);
        chk("5a_valid", 32'(rx_valid), 32'd1);
        chk("5a_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("5a_ov", 32'(ov_cnt - ov0), 32'd0);

`ifdef UART_RX_PARITY_EN
        read_pulse();
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_good_data", 32'(rx_data), 32'h07);
        chk("par_good_valid", 32'(rx_valid), 32'd1);
        chk("par_good_pe", 32'(pe_cnt - pe0), 32'd0);
        read_pulse();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
        chk("par_bad_valid", 32'(rx_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
